// File: rtl/dec_wr_scheduler_pkg.sv
// dec_wr_scheduler_pkg: FSM encoding and AXI burst geometry shared by the write scheduler
package dec_wr_scheduler_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
    localparam int BEAT_BYTES = 64;
    localparam int BOUNDARY   = 4096;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int BOUND_BITS = $clog2(BOUNDARY);
endpackage

// File: rtl/dec_wr_scheduler_rr_arbiter.sv
// dec_wr_scheduler_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module dec_wr_scheduler_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        // descending scan over a doubled range: the lowest position at or after ptr wins, wrapping
        for (int i = 2 * N - 1; i >= 0; i--)
            if (i >= int'(ptr) && req[i % N]) idx = IW'(i % N);
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/dec_wr_scheduler.sv
// dec_wr_scheduler: round-robin AXI write-burst scheduler for NUM_DECOMPRESSOR job slots
// One burst in flight at a time; the grant is held from AW request until its BRESP.
module dec_wr_scheduler
    import dec_wr_scheduler_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int NUM_DECOMPRESSOR   = 2,
    parameter int MAX_BEATS          = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          job_valid_i,
    input  logic [15:0]                   job_id_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] des_addr,
    input  logic [31:0]                   decompression_length,
    output logic                          job_drop_o,
    input  logic [NUM_DECOMPRESSOR-1:0]   dec_burst_rdy,
    input  logic [NUM_DECOMPRESSOR-1:0]   dec_wvalid,
    output logic                          wr_req,
    input  logic                          wr_req_ack,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_address,
    output logic [7:0]                    wr_len,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic                          wr_wlast,
    output logic [NUM_DECOMPRESSOR-1:0]   wr_dec_valid,
    output logic                          bready,
    input  logic                          bresp,
    output logic [NUM_DECOMPRESSOR-1:0]   slot_done_o
);
    localparam int N  = NUM_DECOMPRESSOR;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q [N];
    logic [AW-1:0] addr_d [N];
    logic [31:0]   rem_q [N];
    logic [31:0]   rem_d [N];
    logic [N-1:0]  done_q, done_d, oh_q, oh_d, eligible, arb_gnt;
    logic [IW-1:0] grant_q, grant_d, rr_q, rr_d, arb_idx, job_slot;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    len_q, len_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          drop_q, drop_d, arb_any, job_active, beat;
    logic [31:0]   sel_rem, need, bound, beats, burst_bytes;

    always_comb begin
        eligible = dec_burst_rdy;
        for (int j = 0; j < N; j++) eligible[j] = dec_burst_rdy[j] & (rem_q[j] != '0);
    end

    dec_wr_scheduler_rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req (eligible),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // burst length is the tightest of the beat cap, the 4 KB page edge and the bytes left
    always_comb begin
        sel_rem     = rem_q[arb_idx];
        need        = (sel_rem >> BEAT_SHIFT) + 32'(sel_rem[BEAT_SHIFT-1:0] != '0);
        bound       = (BOUNDARY - 32'(addr_q[arb_idx][BOUND_BITS-1:0])) >> BEAT_SHIFT;
        beats       = (need < bound) ? need : bound;
        beats       = (beats < 32'(MAX_BEATS)) ? beats : 32'(MAX_BEATS);
        burst_bytes = (32'(len_q) + 32'd1) << BEAT_SHIFT;
    end

    assign job_slot   = job_id_i[IW-1:0];
    assign job_active = (rem_q[job_slot] != '0) || (state_q != S_IDLE && grant_q == job_slot);
    assign beat       = wr_valid & wr_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        oh_d    = oh_q;
        rr_d    = rr_q;
        waddr_d = waddr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = done_q;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: if (arb_any) begin
                state_d = S_ADDR;
                grant_d = arb_idx;
                oh_d    = arb_gnt;
                waddr_d = addr_q[arb_idx];
                len_d   = 8'(beats - 32'd1);
            end
            S_ADDR: if (wr_req_ack) begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: if (beat) begin
                cnt_d   = cnt_q + 7'd1;
                state_d = wr_wlast ? S_RESP : S_DATA;
            end
            S_RESP: if (bresp) begin
                state_d         = S_IDLE;
                addr_d[grant_q] = addr_q[grant_q] + AW'(burst_bytes);
                rem_d[grant_q]  = (rem_q[grant_q] > burst_bytes) ? rem_q[grant_q] - burst_bytes : '0;
                done_d[grant_q] = rem_q[grant_q] <= burst_bytes;
                rr_d            = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // a load never targets the granted slot, so it cannot collide with the RESP update above
        if (job_valid_i && (job_id_i >= 16'(N) || job_active)) drop_d = 1'b1;
        else if (job_valid_i) begin
            addr_d[job_slot] = des_addr & ~AW'(BEAT_BYTES - 1);
            rem_d[job_slot]  = decompression_length;
            done_d[job_slot] = decompression_length == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '{default: '0};
            rem_q   <= '{default: '0};
            done_q  <= '0;
            oh_q    <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            waddr_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            oh_q    <= oh_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            waddr_q <= waddr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        wr_req       = state_q == S_ADDR;
        wr_address   = waddr_q;
        wr_len       = len_q;
        wr_valid     = state_q == S_DATA && |(oh_q & dec_wvalid);
        wr_wlast     = state_q == S_DATA && cnt_q == len_q[6:0];
        wr_dec_valid = (state_q == S_DATA) ? oh_q : '0;
        bready       = state_q == S_RESP;
        job_drop_o   = drop_q;
        slot_done_o  = done_q;
    end
endmodule

// File: tb/tb_dec_wr_scheduler.sv
// tb_dec_wr_scheduler: directed jobs with an AW/W/B scoreboard checked by a negedge monitor
module tb_dec_wr_scheduler;
    localparam int N  = 2;
    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid_i, job_drop_o, wr_req, wr_req_ack, wr_valid, wr_ready, wr_wlast, bready, bresp;
    logic [15:0]   job_id_i;
    logic [AW-1:0] des_addr, wr_address;
    logic [31:0]   decompression_length;
    logic [N-1:0]  dec_burst_rdy, dec_wvalid, wr_dec_valid, slot_done_o;
    logic [7:0]    wr_len;

    typedef struct {
        int            slot;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    int   vectors = 0, miscompares = 0;
    bit   stall = 0, in_burst = 0, outstanding = 0;
    int   bdelay = 0, bcnt = 0, cur_slot = 0, beat_cnt = 0;
    logic [7:0] cur_len = '0;

    always #5 clk = ~clk;

    dec_wr_scheduler #(.C_M_AXI_ADDR_WIDTH(AW), .NUM_DECOMPRESSOR(N), .MAX_BEATS(64)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .job_valid_i          (job_valid_i),
        .job_id_i             (job_id_i),
        .des_addr             (des_addr),
        .decompression_length (decompression_length),
        .job_drop_o           (job_drop_o),
        .dec_burst_rdy        (dec_burst_rdy),
        .dec_wvalid           (dec_wvalid),
        .wr_req               (wr_req),
        .wr_req_ack           (wr_req_ack),
        .wr_address           (wr_address),
        .wr_len               (wr_len),
        .wr_valid             (wr_valid),
        .wr_ready             (wr_ready),
        .wr_wlast             (wr_wlast),
        .wr_dec_valid         (wr_dec_valid),
        .bready               (bready),
        .bresp                (bresp),
        .slot_done_o          (slot_done_o)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_burst(input int s, input logic [AW-1:0] a, input logic [7:0] l);
        sbq.push_back('{slot: s, addr: a, len: l});
    endtask

    task automatic load(input int id, input logic [AW-1:0] a, input int len, input bit exp_drop);
        job_valid_i          = 1'b1;
        job_id_i             = 16'(id);
        des_addr             = a;
        decompression_length = 32'(len);
        @(posedge clk); #1;
        job_valid_i = 1'b0;
        chk("job_drop", job_drop_o, exp_drop);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sbq.size() != 0 || outstanding) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("idle_timeout", t >= 20000, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // AXI slave and decompressor data model
    initial begin
        wr_req_ack = 1'b0;
        wr_ready   = 1'b0;
        bresp      = 1'b0;
        dec_wvalid = '0;
        forever begin
            @(posedge clk); #1;
            wr_req_ack = wr_req && (!stall || $urandom_range(0, 2) == 0);
            wr_ready   = !stall || $urandom_range(0, 1) == 1;
            dec_wvalid = stall ? N'($urandom) : '1;
            if (bready) begin
                bresp = bcnt >= bdelay;
                bcnt++;
            end else begin
                bresp = 1'b0;
                bcnt  = 0;
            end
        end
    end

    // monitor: pops the scoreboard on each AW handshake and tracks beats up to wlast
    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_burst    = 0;
            outstanding = 0;
            beat_cnt    = 0;
        end else begin
            chk("dec_valid", wr_dec_valid, in_burst ? (N'(1) << cur_slot) : '0);
            chk("wvalid", wr_valid, in_burst && dec_wvalid[cur_slot]);
            if (wr_req && wr_req_ack) begin
                chk("aw_overlap", outstanding, 0);
                chk("aw_expected", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("aw_addr", wr_address, e.addr);
                    chk("aw_len", wr_len, e.len);
                    chk("aw_4k", int'(wr_address[11:0]) + (int'(wr_len) + 1) * 64 <= 4096, 1);
                    cur_slot = e.slot;
                    cur_len  = e.len;
                end
                beat_cnt    = 0;
                in_burst    = 1;
                outstanding = 1;
            end else if (in_burst && wr_valid && wr_ready) begin
                chk("wlast", wr_wlast, beat_cnt == int'(cur_len));
                if (beat_cnt == int'(cur_len)) in_burst = 0;
                beat_cnt++;
            end
            if (bready && bresp) begin
                chk("bresp_after_data", in_burst, 0);
                outstanding = 0;
            end
        end
    end

    initial begin
        job_valid_i          = 1'b0;
        job_id_i             = '0;
        des_addr             = '0;
        decompression_length = '0;
        dec_burst_rdy        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {wr_req, wr_valid, wr_wlast, bready, job_drop_o, wr_dec_valid,
                              slot_done_o, wr_len, wr_address}, '0);
        rst = 1'b0;

        // single 256 B job
        dec_burst_rdy = 2'b01;
        expect_burst(0, 64'h1000, 8'd3);
        load(0, 64'h1000, 256, 0);
        wait_idle();
        chk("done_t1", slot_done_o, 2'b01);

        // 5000 B starting one beat short of a 4 KB page
        expect_burst(0, 64'h0FC0, 8'd0);
        expect_burst(0, 64'h1000, 8'd63);
        expect_burst(0, 64'h2000, 8'd13);
        load(0, 64'h0FC0, 5000, 0);
        chk("done_cleared", slot_done_o, 2'b00);
        wait_idle();
        chk("done_t2", slot_done_o, 2'b01);

        // two slots contend: grants alternate starting from slot 0
        do_reset();
        dec_burst_rdy = 2'b00;
        load(0, 64'h10000, 8192, 0);
        load(1, 64'h20000, 8192, 0);
        expect_burst(0, 64'h10000, 8'd63);
        expect_burst(1, 64'h20000, 8'd63);
        expect_burst(0, 64'h11000, 8'd63);
        expect_burst(1, 64'h21000, 8'd63);
        dec_burst_rdy = 2'b11;
        wait_idle();
        chk("done_t3", slot_done_o, 2'b11);

        // drops: busy slot, out-of-range id, granted slot during a slow BRESP
        dec_burst_rdy = 2'b00;
        load(0, 64'h3000, 640, 0);
        load(0, 64'h9000, 64, 1);
        load(5, 64'h9000, 64, 1);
        expect_burst(0, 64'h3000, 8'd9);
        bdelay        = 20;
        dec_burst_rdy = 2'b01;
        for (int t = 0; t < 2000 && !bready; t++) begin
            @(posedge clk); #1;
        end
        chk("wait_bready", bready, 1);
        load(0, 64'h9000, 64, 1);
        load(1, 64'h5000, 128, 0);
        expect_burst(1, 64'h5000, 8'd1);
        dec_burst_rdy = 2'b11;
        wait_idle();
        chk("done_t4", slot_done_o, 2'b11);

        // random W/AW stalls with delayed BRESP
        stall         = 1;
        dec_burst_rdy = 2'b00;
        load(0, 64'h40000, 3000, 0);
        load(1, 64'h50040, 4100, 0);
        expect_burst(0, 64'h40000, 8'd46);
        expect_burst(1, 64'h50040, 8'd62);
        expect_burst(1, 64'h51000, 8'd1);
        dec_burst_rdy = 2'b11;
        wait_idle();
        chk("done_t5", slot_done_o, 2'b11);
        stall  = 0;
        bdelay = 0;

        // reset in the middle of a data phase, then a fresh job
        expect_burst(0, 64'h6000, 8'd63);
        load(0, 64'h6000, 4096, 0);
        for (int t = 0; t < 2000 && wr_dec_valid == '0; t++) begin
            @(posedge clk); #1;
        end
        chk("wait_data", wr_dec_valid != '0, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_outputs", {wr_req, wr_valid, wr_wlast, bready, job_drop_o, wr_dec_valid,
                                  slot_done_o, wr_len, wr_address}, '0);
        rst = 1'b0;
        expect_burst(1, 64'h7000, 8'd2);
        load(1, 64'h7000, 192, 0);
        wait_idle();
        chk("done_t6", slot_done_o, 2'b10);

        // zero-length job completes without a burst
        load(0, 64'h8000, 0, 0);
        chk("done_zero_len", slot_done_o, 2'b11);
        wait_idle();
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
